mem_bus_map: RTL and testbench



---
 rtl/mem_bus_map_pkg.sv | 44 ++++
 rtl/mem_bus_map_fifo.sv | 61 ++++++
 rtl/mem_bus_map.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_bus_map.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_map_pkg.sv
// mem_bus_map_pkg: MMIO address map, status bit layout and address-region decode.
// The timer addresses decode only when MEM_BUS_MAP_TIMER_EN is defined.
package mem_bus_map_pkg;

    localparam logic [31:0] UART_DATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h8000_0004;
    localparam logic [31:0] TIMER_LO_ADDR  = 32'h8000_0010;
    localparam logic [31:0] TIMER_HI_ADDR  = 32'h8000_0014;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_UART_DATA,
        REG_UART_STAT,
        REG_TIMER_LO,
        REG_TIMER_HI,
        REG_NONE
    } region_e;

    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_base,
                                              input int          ram_aw);
        logic [31:0] waddr;
        logic [31:0] ram_mask;
        waddr    = {addr[31:2], 2'b00};
        ram_mask = ~((32'd1 << (ram_aw + 2)) - 32'd1);
        if ((waddr & ram_mask) == (ram_base & ram_mask)) return REG_RAM;
        if (waddr == UART_DATA_ADDR) return REG_UART_DATA;
        if (waddr == UART_STAT_ADDR) return REG_UART_STAT;
`ifdef MEM_BUS_MAP_TIMER_EN
        if (waddr == TIMER_LO_ADDR) return REG_TIMER_LO;
        if (waddr == TIMER_HI_ADDR) return REG_TIMER_HI;
`endif
        return REG_NONE;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/mem_bus_map_fifo.sv
// mem_bus_map_fifo: byte FIFO for the UART TX channel; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module mem_bus_map_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (level_q != '0);
        do_push  = push && ((level_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

endmodule

// File: rtl/mem_bus_map.sv
// mem_bus_map: dual-read RAM, UART TX FIFO and error responder behind the CPU
// instruction/data ports. Optional 64-bit cycle timer via MEM_BUS_MAP_TIMER_EN.
module mem_bus_map
    import mem_bus_map_pkg::*;
#(
    parameter int          RAM_AW     = 12,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter int          READ_LAT   = 1,
    parameter int          UART_DEPTH = 16,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data,
    input  logic        data_req,
    input  logic        data_wren,
    input  logic [3:0]  data_mask,
    output logic [31:0] data_q,
    output logic        data_ack,
    output logic        data_err,
    input  logic [31:0] inst_addr,
    input  logic        inst_req,
    output logic [31:0] inst_q,
    output logic        inst_ack,
    output logic        inst_err,
    output logic        uart_tx_valid,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_ready
);

    localparam int RAM_WORDS = 1 << RAM_AW;
    localparam int LVL_W     = $clog2(UART_DEPTH) + 1;

    logic [31:0]       mem [RAM_WORDS];
    logic [RAM_AW-1:0] d_idx, i_idx;
    region_e           d_region, i_region;

    logic        data_ack_q, data_ack_d;
    logic        data_err_q, data_err_d;
    logic [31:0] data_q_q, data_q_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_byte_q, pend_byte_d;
    logic        drd_vld_p1_q, drd_vld_p1_d;
    logic        ird_vld_p1_q, ird_vld_p1_d;
    logic        ird_err_p1_q, ird_err_p1_d;
    logic [31:0] drd_raw_p1_q, ird_raw_p1_q;
    logic [3:0]  dmask_p1_q;

    logic             ram_we, d_busy, fifo_space;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_wdata;
    logic [LVL_W-1:0] fifo_level;
    logic [7:0]       lvl8;
    logic [31:0]      status_word;

    logic [31:0] drd_q, ird_q;
    logic        drd_ack, ird_ack, ird_err;

`ifdef MEM_BUS_MAP_TIMER_EN
    logic [63:0] timer_q, timer_d;
    logic [31:0] shadow_q, shadow_d;
`endif

    assign d_idx    = data_addr[RAM_AW+1:2];
    assign i_idx    = inst_addr[RAM_AW+1:2];
    assign d_region = decode_region(data_addr, RAM_BASE, RAM_AW);
    assign i_region = decode_region(inst_addr, RAM_BASE, RAM_AW);

    assign fifo_pop   = uart_tx_valid && uart_tx_ready;
    assign fifo_space = !fifo_full || fifo_pop;
    // With two-cycle reads the data port stays busy until the read leaves stage 1.
    assign d_busy     = pend_q || ((READ_LAT == 2) && drd_vld_p1_q);

    always_comb begin
        lvl8 = (32'(fifo_level) > 32'd255) ? 8'hFF : 8'(fifo_level);
        status_word = '0;
        status_word[STAT_EMPTY_BIT] = fifo_empty;
        status_word[STAT_FULL_BIT]  = fifo_full;
        status_word[STAT_LEVEL_LSB +: 8] = lvl8;
    end

    always_comb begin
        data_ack_d   = 1'b0;
        data_err_d   = 1'b0;
        data_q_d     = '0;
        pend_d       = pend_q;
        pend_byte_d  = pend_byte_q;
        fifo_push    = 1'b0;
        fifo_wdata   = pend_byte_q;
        ram_we       = 1'b0;
        drd_vld_p1_d = 1'b0;
        ird_vld_p1_d = inst_req;
        ird_err_p1_d = inst_req && (i_region != REG_RAM);
`ifdef MEM_BUS_MAP_TIMER_EN
        timer_d  = timer_q + 64'd1;
        shadow_d = shadow_q;
`endif
        if (pend_q) begin
            if (fifo_space) begin
                fifo_push  = 1'b1;
                data_ack_d = 1'b1;
                pend_d     = 1'b0;
            end
        end else if (data_req && !d_busy) begin
            case (d_region)
                REG_RAM: begin
                    if (data_wren) begin
                        ram_we     = 1'b1;
                        data_ack_d = 1'b1;
                    end else begin
                        drd_vld_p1_d = 1'b1;
                    end
                end
                REG_UART_DATA: begin
                    if (!data_wren) begin
                        data_ack_d = 1'b1;
                    end else if (fifo_space) begin
                        fifo_push  = 1'b1;
                        fifo_wdata = data_data[7:0];
                        data_ack_d = 1'b1;
                    end else begin
                        pend_d      = 1'b1;
                        pend_byte_d = data_data[7:0];
                    end
                end
                REG_UART_STAT: begin
                    data_ack_d = 1'b1;
                    if (!data_wren) data_q_d = status_word;
                end
`ifdef MEM_BUS_MAP_TIMER_EN
                REG_TIMER_LO: begin
                    data_ack_d = 1'b1;
                    if (!data_wren) begin
                        data_q_d = timer_q[31:0];
                        shadow_d = timer_q[63:32];
                    end
                end
                REG_TIMER_HI: begin
                    data_ack_d = 1'b1;
                    if (!data_wren) data_q_d = shadow_q;
                end
`endif
                default: begin
                    data_ack_d = 1'b1;
                    data_err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_ack_q   <= 1'b0;
            data_err_q   <= 1'b0;
            data_q_q     <= '0;
            pend_q       <= 1'b0;
            drd_vld_p1_q <= 1'b0;
            ird_vld_p1_q <= 1'b0;
            ird_err_p1_q <= 1'b0;
        end else begin
            data_ack_q   <= data_ack_d;
            data_err_q   <= data_err_d;
            data_q_q     <= data_q_d;
            pend_q       <= pend_d;
            drd_vld_p1_q <= drd_vld_p1_d;
            ird_vld_p1_q <= ird_vld_p1_d;
            ird_err_p1_q <= ird_err_p1_d;
        end
    end

    // RAM array and read stage: no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_mask[b]) mem[d_idx][8*b +: 8] <= data_data[8*b +: 8];
            end
        end
        drd_raw_p1_q <= mem[d_idx];
        ird_raw_p1_q <= mem[i_idx];
        dmask_p1_q   <= data_mask;
        pend_byte_q  <= pend_byte_d;
    end

    if (READ_LAT == 2) begin : g_lat2
        logic        drd_vld_p2_q, ird_vld_p2_q, ird_err_p2_q;
        logic [31:0] drd_p2_q, ird_p2_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                drd_vld_p2_q <= 1'b0;
                drd_p2_q     <= '0;
                ird_vld_p2_q <= 1'b0;
                ird_err_p2_q <= 1'b0;
                ird_p2_q     <= '0;
            end else begin
                drd_vld_p2_q <= drd_vld_p1_q;
                drd_p2_q     <= drd_vld_p1_q ? (drd_raw_p1_q & lane_mask(dmask_p1_q)) : '0;
                ird_vld_p2_q <= ird_vld_p1_q;
                ird_err_p2_q <= ird_vld_p1_q && ird_err_p1_q;
                ird_p2_q     <= (ird_vld_p1_q && !ird_err_p1_q) ? ird_raw_p1_q : '0;
            end
        end

        assign drd_ack = drd_vld_p2_q;
        assign drd_q   = drd_p2_q;
        assign ird_ack = ird_vld_p2_q;
        assign ird_err = ird_err_p2_q;
        assign ird_q   = ird_p2_q;
    end else begin : g_lat1
        assign drd_ack = drd_vld_p1_q;
        assign drd_q   = drd_vld_p1_q ? (drd_raw_p1_q & lane_mask(dmask_p1_q)) : '0;
        assign ird_ack = ird_vld_p1_q;
        assign ird_err = ird_vld_p1_q && ird_err_p1_q;
        assign ird_q   = (ird_vld_p1_q && !ird_err_p1_q) ? ird_raw_p1_q : '0;
    end

`ifdef MEM_BUS_MAP_TIMER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q  <= '0;
            shadow_q <= '0;
        end else begin
            timer_q  <= timer_d;
            shadow_q <= shadow_d;
        end
    end
`endif

    mem_bus_map_fifo #(
        .DEPTH (UART_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (uart_tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign uart_tx_valid = !fifo_empty;
    assign data_ack      = data_ack_q | drd_ack;
    assign data_q        = data_q_q | drd_q;
    assign data_err      = data_err_q;
    assign inst_ack      = ird_ack;
    assign inst_q        = ird_q;
    assign inst_err      = ird_err;

endmodule

// File: tb/tb_mem_bus_map.sv
// tb_mem_bus_map: directed vector table for the data port plus hand sequences
// for fetch pipelining, UART back-pressure, reset abort and the timer.
module tb_mem_bus_map;

    localparam int          RAM_AW     = 12;
    localparam int          READ_LAT   = 2;
    localparam int          UART_DEPTH = 16;
    localparam logic [31:0] UART_D     = 32'h8000_0000;
    localparam logic [31:0] UART_S     = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] data_addr, data_data, data_q, inst_addr, inst_q;
    logic        data_req, data_wren, data_ack, data_err;
    logic [3:0]  data_mask;
    logic        inst_req, inst_ack, inst_err;
    logic        uart_tx_valid, uart_tx_ready;
    logic [7:0]  uart_tx_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        logic [3:0]  mask;
        logic [31:0] exp_q;
        logic        exp_err;
        int          exp_lat;
        string       name;
    } vec_t;

    vec_t vecs[17];

    mem_bus_map #(
        .RAM_AW     (RAM_AW),
        .RAM_BASE   (32'h0000_0000),
        .READ_LAT   (READ_LAT),
        .UART_DEPTH (UART_DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_addr     (data_addr),
        .data_data     (data_data),
        .data_req      (data_req),
        .data_wren     (data_wren),
        .data_mask     (data_mask),
        .data_q        (data_q),
        .data_ack      (data_ack),
        .data_err      (data_err),
        .inst_addr     (inst_addr),
        .inst_req      (inst_req),
        .inst_q        (inst_q),
        .inst_ack      (inst_ack),
        .inst_err      (inst_err),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_ready (uart_tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic data_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                            input logic [3:0] m, output logic [31:0] q, output logic e,
                            output int lat);
        data_addr = a;
        data_data = wd;
        data_wren = we;
        data_mask = m;
        data_req  = 1'b1;
        tick();
        data_req = 1'b0;
        lat = 1;
        while (!data_ack && lat < 20) begin
            tick();
            lat++;
        end
        q = data_q;
        e = data_err;
        if (!data_ack) lat = -1;
    endtask

    initial begin
        logic [31:0] q;
        logic        e;
        int          lat;
        logic        seen;

        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 4'b0101, 32'h0,         1'b0, 1,        "ram_wr_masked"};
        vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 4'hF,    32'h00AD_00EF, 1'b0, READ_LAT, "ram_rd_masked_word"};
        vecs[2]  = '{32'h0000_0012, 32'h0,         1'b0, 4'b0001, 32'h0000_00EF, 1'b0, READ_LAT, "ram_rd_lane0_lowbits"};
        vecs[3]  = '{32'h0000_0000, 32'h1111_1111, 1'b1, 4'hF,    32'h0,         1'b0, 1,        "ram_wr_w0"};
        vecs[4]  = '{32'h0000_0004, 32'h2222_2222, 1'b1, 4'hF,    32'h0,         1'b0, 1,        "ram_wr_w1"};
        vecs[5]  = '{32'h0000_0008, 32'h3333_3333, 1'b1, 4'hF,    32'h0,         1'b0, 1,        "ram_wr_w2"};
        vecs[6]  = '{32'h0000_0004, 32'h0,         1'b0, 4'hF,    32'h2222_2222, 1'b0, READ_LAT, "ram_rd_w1"};
        vecs[7]  = '{32'h0000_3FFC, 32'hCAFE_F00D, 1'b1, 4'hF,    32'h0,         1'b0, 1,        "ram_wr_top"};
        vecs[8]  = '{32'h0000_3FFC, 32'h0,         1'b0, 4'b1100, 32'hCAFE_0000, 1'b0, READ_LAT, "ram_rd_top_hi"};
        vecs[9]  = '{32'h0000_4000, 32'h0,         1'b0, 4'hF,    32'h0,         1'b1, 1,        "rd_past_ram"};
        vecs[10] = '{32'h4000_0000, 32'h0,         1'b0, 4'hF,    32'h0,         1'b1, 1,        "rd_unmapped"};
        vecs[11] = '{32'h4000_0000, 32'h5555_5555, 1'b1, 4'hF,    32'h0,         1'b1, 1,        "wr_unmapped"};
        vecs[12] = '{UART_S,        32'h0,         1'b0, 4'hF,    32'h0000_0001, 1'b0, 1,        "stat_empty"};
        vecs[13] = '{UART_D,        32'h0,         1'b0, 4'hF,    32'h0,         1'b0, 1,        "uart_data_rd"};
        vecs[14] = '{UART_S,        32'hFFFF_FFFF, 1'b1, 4'hF,    32'h0,         1'b0, 1,        "stat_wr_ignored"};
        vecs[15] = '{UART_S,        32'h0,         1'b0, 4'hF,    32'h0000_0001, 1'b0, 1,        "stat_after_wr"};
        vecs[16] = '{32'h0000_0000, 32'h0,         1'b0, 4'hF,    32'h1111_1111, 1'b0, READ_LAT, "ram_w0_no_alias"};

        reset_n = 1'b0;
        data_addr = '0; data_data = '0; data_req = 1'b0; data_wren = 1'b0; data_mask = '0;
        inst_addr = '0; inst_req = 1'b0; uart_tx_ready = 1'b0;
        tick();
        tick();
        chk("rst_data_ack", data_ack, 0);
        chk("rst_inst_ack", inst_ack, 0);
        chk("rst_data_q", data_q, 0);
        chk("rst_tx_valid", uart_tx_valid, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            data_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wren, vecs[i].mask, q, e, lat);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            chk({vecs[i].name, "_q"}, q, vecs[i].exp_q);
            chk({vecs[i].name, "_err"}, e, vecs[i].exp_err);
        end

        // Back-to-back fetches, acks READ_LAT cycles later and in order.
        inst_addr = 32'h0; inst_req = 1'b1;
        tick();
        chk("inst_no_early_ack", inst_ack, 0);
        inst_addr = 32'h4;
        tick();
        chk("inst0_ack", inst_ack, 1);
        chk("inst0_q", inst_q, 32'h1111_1111);
        inst_addr = 32'h8;
        tick();
        chk("inst1_ack", inst_ack, 1);
        chk("inst1_q", inst_q, 32'h2222_2222);
        inst_req = 1'b0;
        tick();
        chk("inst2_ack", inst_ack, 1);
        chk("inst2_q", inst_q, 32'h3333_3333);
        chk("inst2_err", inst_err, 0);
        tick();
        chk("inst_idle", inst_ack, 0);

        inst_addr = 32'h9000_0000; inst_req = 1'b1;
        tick();
        inst_req = 1'b0;
        tick();
        chk("inst_unmapped_ack", inst_ack, 1);
        chk("inst_unmapped_err", inst_err, 1);
        chk("inst_unmapped_q", inst_q, 0);

        // Same-cycle data write and fetch of one word: fetch sees old data.
        data_addr = 32'h8; data_data = 32'h4444_4444; data_wren = 1'b1; data_mask = 4'hF;
        data_req = 1'b1; inst_addr = 32'h8; inst_req = 1'b1;
        tick();
        data_req = 1'b0; inst_req = 1'b0;
        chk("coll_wr_ack", data_ack, 1);
        tick();
        chk("coll_rd_old", inst_q, 32'h3333_3333);
        inst_req = 1'b1;
        tick();
        inst_req = 1'b0;
        tick();
        chk("coll_rd_new", inst_q, 32'h4444_4444);

        // Fill the FIFO, then a 17th write must wait for a pop.
        for (int i = 0; i < UART_DEPTH; i++) begin
            data_txn(UART_D, 32'hA0 + i, 1'b1, 4'hF, q, e, lat);
            chk("uart_fill_lat", lat, 1);
        end
        data_addr = UART_D; data_data = 32'hB0; data_wren = 1'b1; data_req = 1'b1;
        tick();
        data_req = 1'b0; data_data = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (data_ack) seen = 1'b1;
            tick();
        end
        if (data_ack) seen = 1'b1;
        chk("uart_17th_withheld", seen, 0);
        chk("uart_head_valid", uart_tx_valid, 1);
        chk("uart_head_stable", uart_tx_data, 8'hA0);
        uart_tx_ready = 1'b1;
        tick();
        uart_tx_ready = 1'b0;
        chk("uart_17th_ack", data_ack, 1);
        chk("uart_head_next", uart_tx_data, 8'hA1);
        data_txn(UART_S, 32'h0, 1'b0, 4'hF, q, e, lat);
        chk("uart_stat_full", q, 32'h0000_1002);

        uart_tx_ready = 1'b1;
        for (int i = 0; i < UART_DEPTH; i++) begin
            chk("uart_drain_byte", uart_tx_data, 8'hA1 + i);
            tick();
        end
        chk("uart_drained", uart_tx_valid, 0);
        uart_tx_ready = 1'b0;

        // Reset while a full-FIFO write is pending drops it silently.
        for (int i = 0; i < UART_DEPTH; i++) begin
            data_txn(UART_D, 32'h10 + i, 1'b1, 4'hF, q, e, lat);
        end
        data_addr = UART_D; data_data = 32'h77; data_wren = 1'b1; data_req = 1'b1;
        tick();
        data_req = 1'b0;
        tick();
        reset_n = 1'b0;
        #2;
        chk("rst_pend_no_ack", data_ack, 0);
        chk("rst_pend_tx_valid", uart_tx_valid, 0);
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (data_ack) seen = 1'b1;
        end
        chk("rst_pend_dropped", seen, 0);
        data_txn(UART_S, 32'h0, 1'b0, 4'hF, q, e, lat);
        chk("rst_stat_empty", q, 32'h0000_0001);

`ifdef MEM_BUS_MAP_TIMER_EN
        force dut.timer_q = 64'h0000_0000_FFFF_FFF0;
        tick();
        release dut.timer_q;
        data_txn(32'h8000_0010, 32'h0, 1'b0, 4'hF, q, e, lat);
        chk("timer_lo_err", e, 0);
        chk("timer_lo_hi_bits", q[31:4], 28'hFFF_FFFF);
        data_txn(32'h8000_0014, 32'h0, 1'b0, 4'hF, q, e, lat);
        chk("timer_hi_shadow", q, 32'h0);
`else
        data_txn(32'h8000_0010, 32'h0, 1'b0, 4'hF, q, e, lat);
        chk("timer_lo_unmapped_err", e, 1);
        chk("timer_lo_unmapped_lat", lat, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
